// File: rtl/fetch_icache_responder_pkg.sv
// ICacheResponderTypes: shared types, default geometry and address helpers
// for the fetch-stage I-cache responder (fetch_icache_responder).
//
// Contents:
//   - default geometry (lanes, insn width, address width, line size, sets)
//   - derived widths for the default geometry: index, tag, insn-select, line
//   - ICacheRespState: responder FSM states
//   - icAddrField: extract a bit field from an address
package ICacheResponderTypes;

  localparam int ICACHE_FETCH_WIDTH    = 2;
  localparam int ICACHE_INSN_WIDTH     = 32;
  localparam int ICACHE_PHY_ADDR_WIDTH = 32;
  localparam int ICACHE_LINE_INSNS     = 4;
  localparam int ICACHE_NUM_SETS       = 64;

  // Byte offset inside a line = insn select + 2 bits of byte-in-insn.
  localparam int ICACHE_INSN_SEL_W = $clog2(ICACHE_LINE_INSNS);
  localparam int ICACHE_OFFSET_W   = ICACHE_INSN_SEL_W + 2;
  localparam int ICACHE_INDEX_W    = $clog2(ICACHE_NUM_SETS);
  localparam int ICACHE_TAG_W      = ICACHE_PHY_ADDR_WIDTH - ICACHE_OFFSET_W - ICACHE_INDEX_W;

  typedef logic [ICACHE_INDEX_W-1:0]                       ICacheIndexPath;
  typedef logic [ICACHE_TAG_W-1:0]                         ICacheTagPath;
  typedef logic [ICACHE_INSN_SEL_W-1:0]                    ICacheInsnSelPath;
  typedef logic [ICACHE_LINE_INSNS*ICACHE_INSN_WIDTH-1:0]  ICacheLinePath;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    FLUSH
  } ICacheRespState;

  // Returns addr[lsb +: width], zero-extended to 64 bits.
  function automatic logic [63:0] icAddrField(input logic [63:0] addr, input int lsb, input int width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/fetch_icache_responder_line_array.sv
// icache_line_array: storage for the direct-mapped I-cache.
//   - tag+data RAM (one entry per set) with a registered read port
//   - valid bit per set, cleared by reset
//
// Ports:
//   clk, rst (async, active low)
//   rdEn, rdIndex            -> rdValid, rdTag, rdLine one cycle later
//                               (outputs hold while rdEn is low)
//   wrEn, wrIndex, wrTag, wrLine : line refill, sets the valid bit
//   clrEn, clrIndex          : invalidate one set
module icache_line_array #(
  parameter int INDEX_W  = 6,
  parameter int TAG_W    = 22,
  parameter int LINE_W   = 128,
  parameter int NUM_SETS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdEn,
  input  logic [INDEX_W-1:0] rdIndex,
  output logic               rdValid,
  output logic [TAG_W-1:0]   rdTag,
  output logic [LINE_W-1:0]  rdLine,
  input  logic               wrEn,
  input  logic [INDEX_W-1:0] wrIndex,
  input  logic [TAG_W-1:0]   wrTag,
  input  logic [LINE_W-1:0]  wrLine,
  input  logic               clrEn,
  input  logic [INDEX_W-1:0] clrIndex
);

  logic [TAG_W+LINE_W-1:0] ram [NUM_SETS];
  logic [NUM_SETS-1:0]     validReg;
  logic [NUM_SETS-1:0]     validNext;

  // Fill and clear never occur in the same cycle (different FSM states).
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : gValid
    assign validNext[gi] = (wrEn && (wrIndex == INDEX_W'(gi))) ? 1'b1 :
                           (clrEn && (clrIndex == INDEX_W'(gi))) ? 1'b0 :
                           validReg[gi];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validReg <= '0;
    end else begin
      validReg <= validNext;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      ram[wrIndex] <= {wrTag, wrLine};
    end
  end

  // Read register is reset so the fetch data output starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdValid <= 1'b0;
      rdTag   <= '0;
      rdLine  <= '0;
    end else if (rdEn) begin
      rdValid         <= validReg[rdIndex];
      {rdTag, rdLine} <= ram[rdIndex];
    end
  end

endmodule

// File: rtl/fetch_icache_responder.sv
// fetch_icache_responder: direct-mapped I-cache read port for the fetch stage,
// with a single-beat line refill FSM and a whole-cache flush sequencer.
//
// Ports:
//   clk, rst (async, active low)
//   icRE, icReadAddrIn      : read request (bits [1:0] of the address ignored)
//   icReadHit, icReadDataOut: per-lane result one cycle after icRE
//                             (lane i = head + 4*i)
//   memReqValid/Ready/Addr  : line-aligned refill request
//   memRspValid, memRspData : one-beat full-line refill response
//   flushReq, flushDone     : level request / one-cycle completion pulse
//   busy                    : FSM not in IDLE
//
// Optional build macro RSD_ICACHE_PERF_COUNTER_EN adds perfHitCount and
// perfMissCount outputs.
module fetch_icache_responder
  import ICacheResponderTypes::*;
#(
  parameter int FETCH_WIDTH    = ICACHE_FETCH_WIDTH,
  parameter int INSN_WIDTH     = ICACHE_INSN_WIDTH,
  parameter int PHY_ADDR_WIDTH = ICACHE_PHY_ADDR_WIDTH,
  parameter int LINE_INSNS     = ICACHE_LINE_INSNS,
  parameter int NUM_SETS       = ICACHE_NUM_SETS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              icRE,
  input  logic [PHY_ADDR_WIDTH-1:0]         icReadAddrIn,
  output logic [FETCH_WIDTH-1:0]            icReadHit,
  output logic [FETCH_WIDTH*INSN_WIDTH-1:0] icReadDataOut,
  output logic                              memReqValid,
  input  logic                              memReqReady,
  output logic [PHY_ADDR_WIDTH-1:0]         memReqAddr,
  input  logic                              memRspValid,
  input  logic [LINE_INSNS*INSN_WIDTH-1:0]  memRspData,
  input  logic                              flushReq,
  output logic                              flushDone,
  output logic                              busy
`ifdef RSD_ICACHE_PERF_COUNTER_EN
  ,
  output logic [31:0]                       perfHitCount,
  output logic [31:0]                       perfMissCount
`endif
);

  localparam int SEL_W   = $clog2(LINE_INSNS);
  localparam int SELX_W  = SEL_W + 1;
  localparam int OFF_W   = SEL_W + 2;
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = PHY_ADDR_WIDTH - OFF_W - INDEX_W;
  localparam int LINE_W  = LINE_INSNS * INSN_WIDTH;

  ICacheRespState stateReg;

  // Request pipeline: what was asked in cycle N, evaluated in cycle N+1.
  logic                        reqValidReg;
  logic                        reqIdleReg;
  logic [PHY_ADDR_WIDTH-1:2]   reqAddrReg;
  logic [SEL_W-1:0]            reqSel;
  logic [TAG_W-1:0]            reqTag;

  logic                        flushPendingReg;
  logic                        flushReqPrevReg;
  logic [INDEX_W-1:0]          flushCntReg;
  logic                        flushRise;
  logic                        flushArmed;
  logic                        missDetect;
  logic                        lineHit;

  logic [INDEX_W-1:0]          rdIndex;
  logic                        arrValid;
  logic [TAG_W-1:0]            arrTag;
  logic [LINE_W-1:0]           arrLine;
  logic                        wrEn;
  logic [INDEX_W-1:0]          wrIndex;
  logic                        clrEn;

  assign rdIndex = INDEX_W'(icAddrField(64'(icReadAddrIn), OFF_W, INDEX_W));
  assign reqSel  = reqAddrReg[OFF_W-1:2];
  assign reqTag  = reqAddrReg[PHY_ADDR_WIDTH-1 -: TAG_W];

  // The line is written as the response beat is accepted (WAIT -> FILL), so
  // no line-wide holding register is needed; FILL is the one-cycle settle
  // step during which reads still report miss.
  assign wrEn    = (stateReg == WAIT) && memRspValid;
  assign wrIndex = INDEX_W'(icAddrField(64'(memReqAddr), OFF_W, INDEX_W));
  assign clrEn   = (stateReg == FLUSH);

  icache_line_array #(
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_W),
    .NUM_SETS (NUM_SETS)
  ) lineArray (
    .clk      (clk),
    .rst      (rst),
    .rdEn     (icRE),
    .rdIndex  (rdIndex),
    .rdValid  (arrValid),
    .rdTag    (arrTag),
    .rdLine   (arrLine),
    .wrEn     (wrEn),
    .wrIndex  (wrIndex),
    .wrTag    (memReqAddr[PHY_ADDR_WIDTH-1 -: TAG_W]),
    .wrLine   (memRspData),
    .clrEn    (clrEn),
    .clrIndex (flushCntReg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqValidReg <= 1'b0;
      reqIdleReg  <= 1'b0;
      reqAddrReg  <= '0;
    end else begin
      reqValidReg <= icRE;
      reqIdleReg  <= (stateReg == IDLE);
      if (icRE) begin
        reqAddrReg <= icReadAddrIn[PHY_ADDR_WIDTH-1:2];
      end
    end
  end

  assign lineHit = reqValidReg && reqIdleReg && arrValid && (arrTag == reqTag);

  // Lane data wraps inside the line; wrapped lanes are masked by the hit flag.
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : gLane
    logic [SEL_W-1:0] laneIdx;
    assign laneIdx      = reqSel + SEL_W'(gi);
    assign icReadHit[gi] = lineHit &&
                           ((SELX_W'(reqSel) + SELX_W'(gi)) < SELX_W'(LINE_INSNS));
    assign icReadDataOut[gi*INSN_WIDTH +: INSN_WIDTH] = arrLine[laneIdx*INSN_WIDTH +: INSN_WIDTH];
  end

  // Only lane 0 can start a refill, and only while still IDLE; later lanes
  // are fetched again by the front end once lane 0's line is resident.
  assign missDetect = reqValidReg && reqIdleReg && !icReadHit[0] && (stateReg == IDLE);
  assign flushRise  = flushReq && !flushReqPrevReg;
  assign flushArmed = flushPendingReg || flushRise;
  assign busy       = (stateReg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg        <= IDLE;
      memReqValid     <= 1'b0;
      memReqAddr      <= '0;
      flushDone       <= 1'b0;
      flushPendingReg <= 1'b0;
      flushReqPrevReg <= 1'b0;
      flushCntReg     <= '0;
    end else begin
      flushDone       <= 1'b0;
      flushReqPrevReg <= flushReq;
      if (flushRise) begin
        flushPendingReg <= 1'b1;
      end
      case (stateReg)
        IDLE: begin
          // Flush wins over a same-cycle miss; fetch simply re-requests.
          if (flushArmed) begin
            stateReg        <= FLUSH;
            flushPendingReg <= 1'b0;
            flushCntReg     <= '0;
          end else if (missDetect) begin
            stateReg    <= REQ;
            memReqValid <= 1'b1;
            memReqAddr  <= {reqAddrReg[PHY_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        REQ: begin
          if (memReqReady) begin
            memReqValid <= 1'b0;
            stateReg    <= WAIT;
          end
        end
        WAIT: begin
          if (memRspValid) begin
            stateReg <= FILL;
          end
        end
        FILL: begin
          // A flush raised during the refill starts right away, so the line
          // just written is invalidated as well.
          if (flushArmed) begin
            stateReg        <= FLUSH;
            flushPendingReg <= 1'b0;
            flushCntReg     <= '0;
          end else begin
            stateReg <= IDLE;
          end
        end
        FLUSH: begin
          flushCntReg <= flushCntReg + 1'b1;
          if (flushCntReg == INDEX_W'(NUM_SETS - 1)) begin
            flushDone <= 1'b1;
            stateReg  <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

`ifdef RSD_ICACHE_PERF_COUNTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfHitCount  <= '0;
      perfMissCount <= '0;
    end else begin
      if (icReadHit[0]) begin
        perfHitCount <= perfHitCount + 32'd1;
      end
      if (missDetect && !flushArmed) begin
        perfMissCount <= perfMissCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_icache_responder.sv
module tb_fetch_icache_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         icRE = 1'b0;
  logic [31:0]  icReadAddrIn = '0;
  logic [1:0]   icReadHit;
  logic [63:0]  icReadDataOut;
  logic         memReqValid;
  logic         memReqReady = 1'b0;
  logic [31:0]  memReqAddr;
  logic         memRspValid = 1'b0;
  logic [127:0] memRspData = '0;
  logic         flushReq = 1'b0;
  logic         flushDone;
  logic         busy;
`ifdef RSD_ICACHE_PERF_COUNTER_EN
  logic [31:0]  perfHitCount;
  logic [31:0]  perfMissCount;
`endif

  int total = 0;
  int bad = 0;

  localparam logic [127:0] LINE1 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] LINEA = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
  localparam logic [127:0] LINEB = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
  localparam logic [127:0] LINEC = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
  localparam logic [127:0] LINED = {32'hD4, 32'hD3, 32'hD2, 32'hD1};

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  hit;
    logic [31:0] d0;
    logic [31:0] d1;
  } rdExp_t;

  rdExp_t      rdQ[$];
  logic [31:0] reqQ[$];
  logic        respDue = 1'b0;

  fetch_icache_responder dut (
    .clk           (clk),
    .rst           (rst),
    .icRE          (icRE),
    .icReadAddrIn  (icReadAddrIn),
    .icReadHit     (icReadHit),
    .icReadDataOut (icReadDataOut),
    .memReqValid   (memReqValid),
    .memReqReady   (memReqReady),
    .memReqAddr    (memReqAddr),
    .memRspValid   (memRspValid),
    .memRspData    (memRspData),
    .flushReq      (flushReq),
    .flushDone     (flushDone),
    .busy          (busy)
`ifdef RSD_ICACHE_PERF_COUNTER_EN
    ,
    .perfHitCount  (perfHitCount),
    .perfMissCount (perfMissCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; monitors sample on
  // the falling edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic read(input logic [31:0] a, input logic [1:0] h,
                      input logic [31:0] d0, input logic [31:0] d1);
    rdExp_t e;
    e.addr = a; e.hit = h; e.d0 = d0; e.d1 = d1;
    rdQ.push_back(e);
    icRE = 1'b1;
    icReadAddrIn = a;
    cyc();
    icRE = 1'b0;
  endtask

  task automatic waitReq();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (memReqValid) found = 1'b1;
      else cyc();
    end
    chk("req_seen", found, 1'b1);
  endtask

  task automatic handshake(input logic [31:0] expAddr, input int stall);
    for (int i = 0; i < stall; i++) begin
      chk("req_valid_hold", memReqValid, 1'b1);
      chk("req_addr_hold", memReqAddr, expAddr);
      cyc();
    end
    memReqReady = 1'b1;
    cyc();
    memReqReady = 1'b0;
    chk("req_drop", memReqValid, 1'b0);
  endtask

  task automatic respond(input logic [127:0] line);
    memRspValid = 1'b1;
    memRspData = line;
    cyc();
    memRspValid = 1'b0;
    chk("fill_busy", busy, 1'b1);
    cyc();
    chk("fill_to_idle", busy, 1'b0);
  endtask

  // Read-response scoreboard monitor.
  always @(posedge clk) respDue <= icRE;

  always @(negedge clk) begin : monRd
    rdExp_t e;
    if (respDue) begin
      if (rdQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got response with no expectation");
      end else begin
        e = rdQ.pop_front();
        $display("rd addr=%h hit=%b d0=%h d1=%h", e.addr, icReadHit,
                 icReadDataOut[31:0], icReadDataOut[63:32]);
        chk("rd_hit", icReadHit, e.hit);
        if (e.hit[0]) chk("rd_lane0", icReadDataOut[31:0], e.d0);
        if (e.hit[1]) chk("rd_lane1", icReadDataOut[63:32], e.d1);
      end
    end
  end

  // Refill-request scoreboard monitor: a handshake happens on the next edge.
  always @(negedge clk) begin
    if (rst && memReqValid && memReqReady) begin
      if (reqQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got addr 0x%0h", memReqAddr);
      end else begin
        $display("memreq addr=%h", memReqAddr);
        chk("req_addr", memReqAddr, reqQ.pop_front());
      end
    end
  end

  initial begin
    int k;
    logic gap;

    repeat (3) cyc();
    chk("rst_hit", icReadHit, 2'b00);
    chk("rst_data", icReadDataOut, 64'h0);
    chk("rst_req_valid", memReqValid, 1'b0);
    chk("rst_req_addr", memReqAddr, 32'h0);
    chk("rst_flush_done", flushDone, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    cyc();

    // Cold miss and refill.
    reqQ.push_back(32'h1000);
    read(32'h1000, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h1000, 0);
    respond(LINE1);
    read(32'h1000, 2'b11, 32'h11, 32'h22);

    // Line crossing and mid-line head.
    read(32'h100C, 2'b01, 32'h44, 32'h0);
    read(32'h1008, 2'b11, 32'h33, 32'h44);
    repeat (3) begin
      cyc();
      chk("no_req_on_cross", memReqValid, 1'b0);
    end

    // Conflict miss with backpressure.
    reqQ.push_back(32'h1400);
    read(32'h1400, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h1400, 5);
    respond(LINEA);
    read(32'h1400, 2'b11, 32'hA1, 32'hA2);
    reqQ.push_back(32'h1000);
    read(32'h1000, 2'b00, 32'h0, 32'h0);
    waitReq();
    read(32'h1400, 2'b00, 32'h0, 32'h0);   // resident, but issued during REQ
    handshake(32'h1000, 0);
    respond(LINE1);
    read(32'h1000, 2'b11, 32'h11, 32'h22);

    // Second set, head in the middle of the line.
    reqQ.push_back(32'h2010);
    read(32'h2010, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h2010, 2);
    respond(LINEB);
    read(32'h2014, 2'b11, 32'hB2, 32'hB3);

    // Flush from IDLE.
    flushReq = 1'b1;
    cyc();
    chk("flush_busy", busy, 1'b1);
    k = 0;
    while (!flushDone && k < 200) begin
      cyc();
      k++;
    end
    chk("flush_latency", k, 64);
    chk("flush_done_idle", busy, 1'b0);
    flushReq = 1'b0;
    cyc();
    chk("flush_done_pulse", flushDone, 1'b0);
    reqQ.push_back(32'h1000);
    read(32'h1000, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h1000, 0);
    respond(LINE1);
    read(32'h1000, 2'b11, 32'h11, 32'h22);
    reqQ.push_back(32'h2010);
    read(32'h2010, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h2010, 0);
    respond(LINEB);

    // Flush raised during WAIT: fill completes, FLUSH follows directly.
    reqQ.push_back(32'h3020);
    read(32'h3020, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h3020, 0);
    flushReq = 1'b1;
    cyc();
    memRspValid = 1'b1;
    memRspData = LINEC;
    cyc();
    memRspValid = 1'b0;
    gap = 1'b0;
    k = 0;
    while (!flushDone && k < 200) begin
      if (!busy) gap = 1'b1;
      cyc();
      k++;
    end
    chk("wait_flush_latency", k, 65);
    chk("wait_flush_no_idle_gap", gap, 1'b0);
    flushReq = 1'b0;
    reqQ.push_back(32'h3020);
    read(32'h3020, 2'b00, 32'h0, 32'h0);
    read(32'h1000, 2'b00, 32'h0, 32'h0);   // second miss must not queue a refill
    waitReq();
    handshake(32'h3020, 0);
    respond(LINEC);
    read(32'h3020, 2'b11, 32'hC1, 32'hC2);

    // Reset in WAIT; a late response must be ignored.
    reqQ.push_back(32'h1000);
    read(32'h1000, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h1000, 0);
    chk("wait_busy", busy, 1'b1);
    rst = 1'b0;
    cyc();
    cyc();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_req_valid", memReqValid, 1'b0);
    rst = 1'b1;
    cyc();
    memRspValid = 1'b1;
    memRspData = LINED;
    cyc();
    memRspValid = 1'b0;
    cyc();
    chk("late_rsp_busy", busy, 1'b0);
    reqQ.push_back(32'h1000);
    read(32'h1000, 2'b00, 32'h0, 32'h0);
    waitReq();
    handshake(32'h1000, 0);
    respond(LINE1);
    read(32'h1000, 2'b11, 32'h11, 32'h22);

    repeat (2) cyc();
    chk("rd_queue_left", rdQ.size(), 0);
    chk("req_queue_left", reqQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
